conv3x3_seq_ctrl: RTL and testbench
===================================

# conv3x3_seq_ctrl

Sequencer that wraps the combinational `conv3x3` filter with a streaming front end and back end. It accepts a frame size, then nine kernel coefficients and `rows*cols` Q8.8 pixels, one word per cycle. It assembles them into the flat `matrix_data`/`K00..K22` operands, snapshots `filtered_matrix`, and streams the `(rows-2)*(cols-2)` results out row-major under valid/ready. It is the block that lets image-pipeline stages feed the filter without holding a full 8x8 bus.

## Interface
- `total_bits`, 16, word width (Q8.8 signed)
- `frac_bits`, 8, fractional bits, passed to `conv3x3`
- `max_rows`, 8, maximum frame rows
- `max_cols`, 8, maximum frame columns
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `cfg_valid`  in  1  frame size offered
- `cfg_rows`  in  4  frame rows
- `cfg_cols`  in  4  frame columns
- `cfg_ready`  out  1  high only in IDLE
- `cfg_err`  out  1  one-cycle pulse: config rejected
- `in_valid`  in  1  input word offered
- `in_data`  in  total_bits  kernel word, then pixel word (signed)
- `in_ready`  out  1  high in LOAD_K and LOAD_PIX
- `out_valid`  out  1  result word valid
- `out_data`  out  total_bits  filtered result (signed Q8.8)
- `out_last`  out  1  qualifies the final result of the frame
- `out_ready`  in  1  downstream accepts
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after the final output handshake

## Operation
- States: IDLE, LOAD_K, LOAD_PIX, COMPUTE, DRAIN.
- **IDLE**
  - A `cfg_valid&&cfg_ready` handshake latches rows and cols.
  - Legal size is `3<=rows<=max_rows` and `3<=cols<=max_cols`.
  - On a legal size: clear the whole pixel buffer to 0, go to LOAD_K.
  - On an illegal size: pulse `cfg_err` and stay in IDLE.
- **LOAD_K**
  - Accept exactly 9 words, row-major K00, K01, K02, K10 … K22.
  - Go to LOAD_PIX after the 9th handshake.
- **LOAD_PIX**
  - Accept `rows*cols` words, row-major.
  - Pixel (r,c) is written to `matrix_data[(r*max_cols+c)*total_bits +: total_bits]`.
  - Unused positions stay 0.
  - Go to COMPUTE after the last handshake.
- **COMPUTE** (one cycle): register the whole `filtered_matrix` into the output buffer, then go to DRAIN.
- **DRAIN**
  - Emit result (r,c) for r<rows-2, c<cols-2, row-major.
  - Result (r,c) is read from `filtered[((r*(max_cols-2))+c)*total_bits +: total_bits]`.
  - `out_last` is high with index `(rows-3, cols-3)`.
  - After the last handshake: pulse `done` and return to IDLE.
- Arithmetic belongs to `conv3x3` (sum of products, shifted by `frac_bits`, truncated to `total_bits`). The controller does no arithmetic and does not re-round.
- Counters: row counter 4 bits, column counter 4 bits, kernel counter 4 bits. Column wraps to 0 and row increments at `cols-1`.

## Timing
- Reset values:
  - state = IDLE
  - `cfg_ready`=1, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0
  - `busy`=0, `done`=0, `cfg_err`=0
  - all counters 0
- At most one word per cycle per port. Zero bubbles: the next word may be accepted in the cycle after a handshake.
- Latency: if the last pixel handshake is at edge t, COMPUTE occupies t..t+1 and `out_valid` is high after edge t+1.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_last` are held stable. The address advances only on a handshake.
- `in_valid` outside LOAD_K/LOAD_PIX is ignored. `cfg_valid` while busy is ignored; no error is raised.
- `rst` asserted in any state returns the block to IDLE next edge:
  - all reset values are applied
  - the partial frame is discarded
  - the buffer is re-cleared on the next accepted config
- `cfg_err` and `done` never assert in the same cycle.

## Structure
- Package `conv_pkg`:
  - state enum
  - `KERNEL_TAPS=9`
  - localparams `OUT_ROWS=max_rows-2` and `OUT_COLS=max_cols-2`
- Single sub-module: the existing `conv3x3`, instantiated unchanged with the same parameters.
- Pixel buffer and kernel registers are plain flops (8x8x16 = 1024 bits). No RAM is used.

## Test plan
- **4x4 stripes.** Config 4x4; kernel all 28; pixel = 256 when c even, else 0 -> outputs 168, 84, 168, 84 with `out_last` on the 4th, then `done` pulses.
- **8x8 checkerboard.** Pixel = 256 when (r+c) even; kernel all 28 -> 36 outputs alternating 140/112, starting 140 at (0,0), `out_last` on #36.
- **Backpressure.** Random `out_ready` toggling on the 8x8 run -> identical sequence of 36 values, `out_data` stable while stalled, no drops or duplicates.
- **Illegal config.** cfg 2x5, then 9x4 -> `cfg_err` pulses once each, `busy` stays 0, `in_ready` stays 0.
- **Reset mid-frame.** `rst` after 20 pixels of an 8x8 frame -> IDLE next cycle with all outputs at reset values. A following 4x4 stripes frame yields 168, 84, 168, 84.
- **Stale-data clear.** Run an 8x8 all-256 frame, then a 3x3 frame with kernel K11=256 only and pixels all 0 except center 512 -> single output 512 with `out_last`=1.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing for the 3x3 convolution sequencer
package conv_pkg;

    localparam int TOTAL_BITS  = 16;
    localparam int FRAC_BITS   = 8;
    localparam int MAX_ROWS    = 8;
    localparam int MAX_COLS    = 8;
    localparam int OUT_ROWS    = MAX_ROWS - 2;
    localparam int OUT_COLS    = MAX_COLS - 2;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_PIX,
        S_COMPUTE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/conv3x3.sv
// rtl/conv3x3.sv - combinational valid-region 3x3 filter over a flat Q8.8 frame
module conv3x3 #(
    parameter int total_bits = 16,
    parameter int frac_bits  = 8,
    parameter int max_rows   = 8,
    parameter int max_cols   = 8
) (
    input  logic [max_rows*max_cols*total_bits-1:0]         matrix_data,
    input  logic signed [total_bits-1:0]                    K00,
    input  logic signed [total_bits-1:0]                    K01,
    input  logic signed [total_bits-1:0]                    K02,
    input  logic signed [total_bits-1:0]                    K10,
    input  logic signed [total_bits-1:0]                    K11,
    input  logic signed [total_bits-1:0]                    K12,
    input  logic signed [total_bits-1:0]                    K20,
    input  logic signed [total_bits-1:0]                    K21,
    input  logic signed [total_bits-1:0]                    K22,
    output logic [(max_rows-2)*(max_cols-2)*total_bits-1:0] filtered_matrix
);

    // Nine full-width products plus headroom so the sum never wraps before the shift
    localparam int acc_bits = 2*total_bits + 4;

    logic signed [total_bits-1:0] k [9];
    logic signed [acc_bits-1:0]   acc;
    logic signed [total_bits-1:0] pix;

    assign k[0] = K00;
    assign k[1] = K01;
    assign k[2] = K02;
    assign k[3] = K10;
    assign k[4] = K11;
    assign k[5] = K12;
    assign k[6] = K20;
    assign k[7] = K21;
    assign k[8] = K22;

    always_comb begin
        filtered_matrix = '0;
        acc = '0;
        pix = '0;
        for (int r = 0; r < max_rows-2; r++) begin
            for (int c = 0; c < max_cols-2; c++) begin
                acc = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        pix = matrix_data[((r+i)*max_cols + c + j)*total_bits +: total_bits];
                        acc = acc + acc_bits'(pix) * acc_bits'(k[i*3+j]);
                    end
                end
                filtered_matrix[(r*(max_cols-2) + c)*total_bits +: total_bits] =
                    total_bits'(acc >>> frac_bits);
            end
        end
    end

endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// rtl/conv3x3_seq_ctrl.sv - streaming front/back end that feeds conv3x3 one word per cycle
module conv3x3_seq_ctrl
    import conv_pkg::*;
#(
    parameter int total_bits = TOTAL_BITS,
    parameter int frac_bits  = FRAC_BITS,
    parameter int max_rows   = MAX_ROWS,
    parameter int max_cols   = MAX_COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [3:0]            cfg_rows,
    input  logic [3:0]            cfg_cols,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic                  in_valid,
    input  logic [total_bits-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [total_bits-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int pix_n     = max_rows * max_cols;
    localparam int out_cols  = max_cols - 2;
    localparam int out_n     = (max_rows - 2) * out_cols;
    localparam int pix_idx_w = $clog2(pix_n);
    localparam int out_idx_w = $clog2(out_n);

    state_t state, state_n;

    logic [3:0] row_cnt, col_cnt, k_cnt;
    logic [3:0] rows_q, cols_q;

    logic signed [total_bits-1:0] k_mem [KERNEL_TAPS];
    logic [total_bits-1:0]        pix_mem [pix_n];
    logic [pix_n*total_bits-1:0]  matrix_data;
    logic [out_n*total_bits-1:0]  filtered, filt_buf;

    logic cfg_hs, cfg_legal, in_hs, out_hs;
    logic k_last, pix_col_last, pix_last, out_col_last;
    logic [pix_idx_w-1:0] pix_idx;
    logic [out_idx_w-1:0] out_idx;

    assign cfg_legal = (cfg_rows >= 4'd3) && (cfg_rows <= 4'(max_rows)) &&
                       (cfg_cols >= 4'd3) && (cfg_cols <= 4'(max_cols));
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    assign k_last       = (k_cnt == 4'(KERNEL_TAPS - 1));
    assign pix_col_last = (col_cnt == cols_q - 4'd1);
    assign pix_last     = pix_col_last && (row_cnt == rows_q - 4'd1);
    assign out_col_last = (col_cnt == cols_q - 4'd3);

    assign pix_idx = pix_idx_w'(int'(row_cnt) * max_cols + int'(col_cnt));
    assign out_idx = out_idx_w'(int'(row_cnt) * out_cols + int'(col_cnt));

    // Output is a pure function of state and the drain address, so it holds under stall
    assign out_last = (state == S_DRAIN) && out_col_last && (row_cnt == rows_q - 4'd3);
    assign out_data = (state == S_DRAIN) ? filt_buf[out_idx*total_bits +: total_bits] : '0;

    always_comb begin
        matrix_data = '0;
        for (int i = 0; i < pix_n; i++) begin
            matrix_data[i*total_bits +: total_bits] = pix_mem[i];
        end
    end

    conv3x3 #(
        .total_bits (total_bits),
        .frac_bits  (frac_bits),
        .max_rows   (max_rows),
        .max_cols   (max_cols)
    ) u_conv3x3 (
        .matrix_data     (matrix_data),
        .K00             (k_mem[0]),
        .K01             (k_mem[1]),
        .K02             (k_mem[2]),
        .K10             (k_mem[3]),
        .K11             (k_mem[4]),
        .K12             (k_mem[5]),
        .K20             (k_mem[6]),
        .K21             (k_mem[7]),
        .K22             (k_mem[8]),
        .filtered_matrix (filtered)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cfg_ready = (state == S_IDLE);
        in_ready  = (state == S_LOAD_K) || (state == S_LOAD_PIX);
        out_valid = (state == S_DRAIN);
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:     if (cfg_hs && cfg_legal) state_n = S_LOAD_K;
            S_LOAD_K:   if (in_hs && k_last)     state_n = S_LOAD_PIX;
            S_LOAD_PIX: if (in_hs && pix_last)   state_n = S_COMPUTE;
            S_COMPUTE:                           state_n = S_DRAIN;
            S_DRAIN:    if (out_hs && out_last)  state_n = S_IDLE;
            default:                             state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
            k_cnt   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            cfg_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            cfg_err <= cfg_hs && !cfg_legal;
            done    <= out_hs && out_last;
            case (state)
                S_IDLE: begin
                    if (cfg_hs && cfg_legal) begin
                        rows_q  <= cfg_rows;
                        cols_q  <= cfg_cols;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        k_cnt   <= '0;
                        // Smaller frames rely on untouched positions reading as zero
                        for (int i = 0; i < pix_n; i++) begin
                            pix_mem[i] <= '0;
                        end
                    end
                end
                S_LOAD_K: begin
                    if (in_hs) begin
                        k_mem[k_cnt] <= in_data;
                        k_cnt        <= k_last ? 4'd0 : k_cnt + 4'd1;
                    end
                end
                S_LOAD_PIX: begin
                    if (in_hs) begin
                        pix_mem[pix_idx] <= in_data;
                        if (pix_col_last) begin
                            col_cnt <= '0;
                            row_cnt <= pix_last ? 4'd0 : row_cnt + 4'd1;
                        end else begin
                            col_cnt <= col_cnt + 4'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    filt_buf <= filtered;
                    row_cnt  <= '0;
                    col_cnt  <= '0;
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        if (out_col_last) begin
                            col_cnt <= '0;
                            row_cnt <= out_last ? 4'd0 : row_cnt + 4'd1;
                        end else begin
                            col_cnt <= col_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// tb/tb_conv3x3_seq_ctrl.sv - directed self-checking bench for conv3x3_seq_ctrl
module tb_conv3x3_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [3:0]  cfg_rows;
    logic [3:0]  cfg_cols;
    logic        cfg_ready;
    logic        cfg_err;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv3x3_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_in_ready"},  int'(in_ready),  0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"},  int'(out_data),  0);
        chk({tag, "_out_last"},  int'(out_last),  0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_cfg_err"},   int'(cfg_err),   0);
    endtask

    task automatic send_cfg(input int rows, input int cols);
        cfg_valid = 1'b1;
        cfg_rows  = 4'(rows);
        cfg_cols  = 4'(cols);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic send_word(input int d);
        int t;
        in_valid = 1'b1;
        in_data  = 16'(d);
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic int pix_val(input int ppat, input int r, input int c);
        case (ppat)
            0:       return (c % 2 == 0) ? 256 : 0;
            1:       return ((r + c) % 2 == 0) ? 256 : 0;
            2:       return 256;
            default: return (r == 1 && c == 1) ? 512 : 0;
        endcase
    endfunction

    function automatic int exp_val(input int epat, input int r, input int c);
        case (epat)
            0:       return (c % 2 == 0) ? 168 : 84;
            1:       return ((r + c) % 2 == 0) ? 140 : 112;
            2:       return 512;
            default: return 252;
        endcase
    endfunction

    task automatic load_frame(input int rows, input int cols, input int kpat,
                              input int ppat, input int npix);
        chk("cfg_ready_before_cfg", int'(cfg_ready), 1);
        send_cfg(rows, cols);
        chk("busy_after_cfg", int'(busy), 1);
        for (int k = 0; k < 9; k++) begin
            send_word((kpat == 0) ? 28 : ((k == 4) ? 256 : 0));
        end
        for (int p = 0; p < npix; p++) begin
            send_word(pix_val(ppat, p / cols, p % cols));
        end
    endtask

    task automatic drain(input int n, input int ocols, input int epat, input bit bp);
        int t;
        int expv;
        int stalls;
        chk("compute_out_valid_low", int'(out_valid), 0);
        chk("compute_in_ready_low", int'(in_ready), 0);
        step();
        chk("latency_out_valid", int'(out_valid), 1);
        out_ready = !bp;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!out_valid && t < 50) begin
                step();
                t++;
            end
            chk("out_valid_wait", int'(out_valid), 1);
            expv = exp_val(epat, k / ocols, k % ocols);
            chk($sformatf("out_data_%0d", k), int'($signed(out_data)), expv);
            chk($sformatf("out_last_%0d", k), int'(out_last), (k == n - 1) ? 1 : 0);
            if (bp) begin
                stalls = $urandom_range(0, 2);
                out_ready = 1'b0;
                for (int s = 0; s < stalls; s++) begin
                    step();
                    chk($sformatf("stall_data_%0d", k), int'($signed(out_data)), expv);
                    chk($sformatf("stall_valid_%0d", k), int'(out_valid), 1);
                end
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end else begin
                step();
            end
        end
        out_ready = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("busy_after_frame", int'(busy), 0);
        chk("out_valid_after_frame", int'(out_valid), 0);
        step();
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_rows  = '0;
        cfg_cols  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle_outputs("reset");

        load_frame(4, 4, 0, 0, 16);
        drain(4, 2, 0, 1'b0);

        load_frame(8, 8, 0, 1, 64);
        drain(36, 6, 1, 1'b0);

        load_frame(8, 8, 0, 1, 64);
        drain(36, 6, 1, 1'b1);

        send_cfg(2, 5);
        chk("err_2x5_pulse", int'(cfg_err), 1);
        chk("err_2x5_busy", int'(busy), 0);
        chk("err_2x5_in_ready", int'(in_ready), 0);
        step();
        chk("err_2x5_clear", int'(cfg_err), 0);
        send_cfg(9, 4);
        chk("err_9x4_pulse", int'(cfg_err), 1);
        chk("err_9x4_busy", int'(busy), 0);
        chk("err_9x4_in_ready", int'(in_ready), 0);
        step();
        chk("err_9x4_clear", int'(cfg_err), 0);

        load_frame(8, 8, 0, 1, 20);
        chk("midframe_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midreset");
        load_frame(4, 4, 0, 0, 16);
        drain(4, 2, 0, 1'b0);

        load_frame(8, 8, 0, 2, 64);
        drain(36, 6, 3, 1'b0);
        load_frame(3, 3, 1, 3, 9);
        drain(1, 1, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
